pipe_stage_slice: RTL and testbench



---
 rtl/pipe_pkg.sv | 37 +++
 rtl/perf_counter.sv | 44 ++++
 rtl/pipe_stage_slice.sv | 193 +++++++++++++++++++
 tb/tb_pipe_stage_slice.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_pkg.sv
// rtl/pipe_pkg.sv - shared types for the pipe_stage_slice valid/ready register slice
//
// Purpose: buffering-mode selector, skid-buffer state encoding and occupancy
// width shared by pipe_stage_slice and its testbench.
// Ports: none (package).

package pipe_pkg;

    // Buffering style of one slice.
    typedef enum logic {
        PIPE_MODE = 1'b0,   // one entry, combinational s_ready
        SKID_MODE = 1'b1    // two entries, registered s_ready
    } mode_e;

    // Number of beats held by the skid buffer.
    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } skid_state_e;

    localparam int unsigned OCC_W = 2;

    typedef logic [OCC_W-1:0] occ_t;

    // Number of held beats for a given skid state.
    function automatic occ_t skid_occ(input skid_state_e st);
        occ_t occ;
        case (st)
            ONE:     occ = occ_t'(1);
            TWO:     occ = occ_t'(2);
            default: occ = occ_t'(0);
        endcase
        return occ;
    endfunction

endpackage

// File: rtl/perf_counter.sv
// rtl/perf_counter.sv - wrapping event counter with synchronous clear
//
// Purpose: counts cycles on which inc is high, wrapping modulo 2^CNT_W.
//          clr wins over inc in the same cycle.
// Ports:
//   clk    in   1      clock
//   rst_n  in   1      asynchronous active-low reset (count -> 0)
//   inc    in   1      increment this cycle
//   clr    in   1      synchronous clear
//   count  out  CNT_W  current count

module perf_counter #(
    parameter int unsigned CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             inc,
    input  logic             clr,
    output logic [CNT_W-1:0] count
);

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (clr) begin
            count_d = '0;
        end else if (inc) begin
            count_d = count_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/pipe_stage_slice.sv
// rtl/pipe_stage_slice.sv - parametrised valid/ready pipeline slice with flush and perf counters
//
// Purpose: carries a DATA_W payload across a valid/ready boundary, either as a
//          plain one-entry pipeline register (MODE=0) or as a two-entry skid
//          buffer with registered s_ready (MODE=1). flush kills every held
//          entry; two counters track completed beats and stalled cycles.
// Ports:
//   clk        in   1       clock
//   rst_n      in   1       asynchronous active-low reset
//   flush      in   1       synchronous kill of every held entry
//   s_valid    in   1       upstream beat valid
//   s_ready    out  1       slice can accept an upstream beat
//   s_data     in   DATA_W  upstream payload
//   m_valid    out  1       downstream beat valid
//   m_ready    in   1       downstream accepts
//   m_data     out  DATA_W  downstream payload
//   occupancy  out  2       number of held entries
//   cnt_clr    in   1       synchronous clear of both counters
//   xfer_cnt   out  CNT_W   completed m_valid&m_ready beats
//   stall_cnt  out  CNT_W   cycles with m_valid&!m_ready

module pipe_stage_slice
    import pipe_pkg::*;
#(
    parameter int unsigned        DATA_W    = 32,
    parameter int unsigned        MODE      = 0,
    parameter logic [DATA_W-1:0]  RESET_VAL = '0,
    parameter int unsigned        CNT_W     = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    input  logic              s_valid,
    output logic              s_ready,
    input  logic [DATA_W-1:0] s_data,
    output logic              m_valid,
    input  logic              m_ready,
    output logic [DATA_W-1:0] m_data,
    output occ_t              occupancy,
    input  logic              cnt_clr,
    output logic [CNT_W-1:0]  xfer_cnt,
    output logic [CNT_W-1:0]  stall_cnt
);

    localparam mode_e MODE_SEL = (MODE == 0) ? PIPE_MODE : SKID_MODE;

    logic xfer;
    logic stall;

    if (MODE_SEL == PIPE_MODE) begin : g_pipe

        logic              valid_q;
        logic              valid_d;
        logic [DATA_W-1:0] data_q;
        logic [DATA_W-1:0] data_d;
        logic              accept;

        // Ready when empty or when the held beat leaves this cycle, which is
        // what gives full throughput with a single entry.
        assign s_ready = !valid_q || m_ready;
        assign accept  = s_valid && s_ready;

        always_comb begin
            valid_d = valid_q;
            data_d  = data_q;
            if (accept && !flush) begin
                data_d = s_data;
            end
            if (flush) begin
                valid_d = 1'b0;
            end else if (accept) begin
                valid_d = 1'b1;
            end else if (m_ready) begin
                valid_d = 1'b0;
            end
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                valid_q <= 1'b0;
                data_q  <= RESET_VAL;
            end else begin
                valid_q <= valid_d;
                data_q  <= data_d;
            end
        end

        assign m_valid   = valid_q;
        assign m_data    = data_q;
        assign occupancy = {1'b0, valid_q};

    end else begin : g_skid

        skid_state_e       state_q;
        skid_state_e       state_d;
        logic [DATA_W-1:0] main_q;
        logic [DATA_W-1:0] main_d;
        logic [DATA_W-1:0] skid_q;
        logic [DATA_W-1:0] skid_d;
        logic              s_ready_q;
        logic              s_ready_d;
        logic              accept;
        logic              pop;

        // main_q always holds the oldest beat and drives m_data; skid_q only
        // holds the beat that arrived while the output was stalled.
        assign accept = s_valid && s_ready_q;
        assign pop    = (state_q != EMPTY) && m_ready;

        always_comb begin
            state_d = state_q;
            main_d  = main_q;
            skid_d  = skid_q;
            case (state_q)
                EMPTY: begin
                    if (accept) begin
                        state_d = ONE;
                        main_d  = s_data;
                    end
                end
                ONE: begin
                    if (accept && !pop) begin
                        state_d = TWO;
                        skid_d  = s_data;
                    end else if (accept && pop) begin
                        main_d  = s_data;
                    end else if (pop) begin
                        state_d = EMPTY;
                    end
                end
                TWO: begin
                    if (pop) begin
                        state_d = ONE;
                        main_d  = skid_q;
                    end
                end
                default: begin
                    state_d = EMPTY;
                end
            endcase
            // Flush only invalidates; payload registers keep whatever they
            // were loaded with.
            if (flush) begin
                state_d = EMPTY;
            end
            s_ready_d = (state_d != TWO);
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                state_q   <= EMPTY;
                main_q    <= RESET_VAL;
                skid_q    <= RESET_VAL;
                s_ready_q <= 1'b1;
            end else begin
                state_q   <= state_d;
                main_q    <= main_d;
                skid_q    <= skid_d;
                s_ready_q <= s_ready_d;
            end
        end

        assign s_ready   = s_ready_q;
        assign m_valid   = (state_q != EMPTY);
        assign m_data    = main_q;
        assign occupancy = skid_occ(state_q);

    end

    assign xfer  = m_valid && m_ready;
    assign stall = m_valid && !m_ready;

    perf_counter #(
        .CNT_W (CNT_W)
    ) u_xfer_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (xfer),
        .clr   (cnt_clr),
        .count (xfer_cnt)
    );

    perf_counter #(
        .CNT_W (CNT_W)
    ) u_stall_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (stall),
        .clr   (cnt_clr),
        .count (stall_cnt)
    );

endmodule

// File: tb/tb_pipe_stage_slice.sv
// tb/tb_pipe_stage_slice.sv - self-checking bench for pipe_stage_slice (PIPE, SKID, narrow counters)

module tb_pipe_stage_slice;
    import pipe_pkg::*;

    localparam int DW = 16;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          flush   [3];
    logic          s_valid [3];
    logic          s_ready [3];
    logic [DW-1:0] s_data  [3];
    logic          m_valid [3];
    logic          m_ready [3];
    logic [DW-1:0] m_data  [3];
    occ_t          occ     [3];
    logic          cnt_clr [3];
    logic [31:0]   xfer    [2];
    logic [31:0]   stall   [2];
    logic [3:0]    xfer4;
    logic [3:0]    stall4;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    // Instance 0: PIPE, instance 1: SKID, instance 2: PIPE with 4-bit counters.
    pipe_stage_slice #(.DATA_W(DW), .MODE(0), .RESET_VAL(16'h0), .CNT_W(32)) u_pipe (
        .clk(clk), .rst_n(rst_n), .flush(flush[0]), .s_valid(s_valid[0]), .s_ready(s_ready[0]),
        .s_data(s_data[0]), .m_valid(m_valid[0]), .m_ready(m_ready[0]), .m_data(m_data[0]),
        .occupancy(occ[0]), .cnt_clr(cnt_clr[0]), .xfer_cnt(xfer[0]), .stall_cnt(stall[0])
    );

    pipe_stage_slice #(.DATA_W(DW), .MODE(1), .RESET_VAL(16'h0), .CNT_W(32)) u_skid (
        .clk(clk), .rst_n(rst_n), .flush(flush[1]), .s_valid(s_valid[1]), .s_ready(s_ready[1]),
        .s_data(s_data[1]), .m_valid(m_valid[1]), .m_ready(m_ready[1]), .m_data(m_data[1]),
        .occupancy(occ[1]), .cnt_clr(cnt_clr[1]), .xfer_cnt(xfer[1]), .stall_cnt(stall[1])
    );

    pipe_stage_slice #(.DATA_W(DW), .MODE(0), .RESET_VAL(16'h0), .CNT_W(4)) u_cnt4 (
        .clk(clk), .rst_n(rst_n), .flush(flush[2]), .s_valid(s_valid[2]), .s_ready(s_ready[2]),
        .s_data(s_data[2]), .m_valid(m_valid[2]), .m_ready(m_ready[2]), .m_data(m_data[2]),
        .occupancy(occ[2]), .cnt_clr(cnt_clr[2]), .xfer_cnt(xfer4), .stall_cnt(stall4)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard per instance: accepted beats are pushed, completed beats are
    // popped and compared; a flush drops whatever is still held.
    for (genvar g = 0; g < 3; g++) begin : mon
        logic [DW-1:0] q[$];
        logic          prev_stall = 1'b0;
        logic [DW-1:0] prev_data  = '0;

        always @(negedge clk) begin
            if (!rst_n) begin
                q.delete();
                prev_stall = 1'b0;
            end else begin
                if (prev_stall && m_valid[g]) begin
                    check($sformatf("hold%0d", g), m_data[g], prev_data);
                end
                if (m_valid[g] && m_ready[g]) begin
                    check($sformatf("sb_nonempty%0d", g), q.size() != 0, 1);
                    if (q.size() != 0) begin
                        check($sformatf("sb_data%0d", g), m_data[g], q.pop_front());
                    end
                end
                if (flush[g]) begin
                    q.delete();
                end else if (s_valid[g] && s_ready[g]) begin
                    q.push_back(s_data[g]);
                end
                prev_stall = m_valid[g] && !m_ready[g];
                prev_data  = m_data[g];
            end
        end
    end

    initial begin
        logic [31:0] x0;

        rst_n = 1'b0;
        for (int i = 0; i < 3; i++) begin
            flush[i]   = 1'b0;
            s_valid[i] = 1'b0;
            s_data[i]  = '0;
            m_ready[i] = 1'b0;
            cnt_clr[i] = 1'b0;
        end

        // Reset held with s_valid high on the PIPE instance.
        s_valid[0] = 1'b1;
        s_data[0]  = 16'h0055;
        repeat (2) tick();
        check("rst_mvalid", m_valid[0], 0);
        check("rst_occ", occ[0], 0);
        check("rst_xfer", xfer[0], 0);
        check("rst_stall", stall[0], 0);
        check("rst_skid_sready", s_ready[1], 1);
        check("rst_skid_mvalid", m_valid[1], 0);
        rst_n = 1'b1;
        tick();
        check("first_mvalid", m_valid[0], 1);
        check("first_mdata", m_data[0], 16'h0055);
        check("first_sready", s_ready[0], 0);
        s_valid[0] = 1'b0;
        m_ready[0] = 1'b1;
        tick();
        check("first_drain", m_valid[0], 0);

        // SKID fill under backpressure, then drain in order.
        s_valid[1] = 1'b1;
        s_data[1]  = 16'h00A1;
        tick();
        s_data[1]  = 16'h00A2;
        tick();
        check("skid_occ2", occ[1], 2);
        check("skid_sready0", s_ready[1], 0);
        s_valid[1] = 1'b0;
        tick();
        check("skid_occ2_hold", occ[1], 2);
        m_ready[1] = 1'b1;
        tick();
        tick();
        check("skid_xfer", xfer[1], 2);
        check("skid_stall", stall[1], 2);
        check("skid_empty", occ[1], 0);
        check("skid_mvalid0", m_valid[1], 0);
        check("skid_sready1", s_ready[1], 1);

        // Streaming at full rate on both modes.
        cnt_clr[0] = 1'b1;
        cnt_clr[1] = 1'b1;
        tick();
        cnt_clr[0] = 1'b0;
        cnt_clr[1] = 1'b0;
        check("clr_xfer0", xfer[0], 0);
        check("clr_stall1", stall[1], 0);
        for (int i = 0; i < 100; i++) begin
            for (int d = 0; d < 2; d++) begin
                s_valid[d] = 1'b1;
                m_ready[d] = 1'b1;
                s_data[d]  = DW'(16'h1000 + i);
            end
            tick();
            check("stream_mvalid0", m_valid[0], 1);
            check("stream_mvalid1", m_valid[1], 1);
            check("stream_sready1", s_ready[1], 1);
        end
        s_valid[0] = 1'b0;
        s_valid[1] = 1'b0;
        tick();
        check("stream_end0", m_valid[0], 0);
        check("stream_end1", m_valid[1], 0);
        check("stream_xfer0", xfer[0], 100);
        check("stream_xfer1", xfer[1], 100);
        check("stream_stall0", stall[0], 0);
        check("stream_stall1", stall[1], 0);
        m_ready[0] = 1'b0;
        m_ready[1] = 1'b0;

        // SKID flush while full, with an upstream beat 0xFF offered.
        s_valid[1] = 1'b1;
        s_data[1]  = 16'h00B1;
        tick();
        s_data[1]  = 16'h00B2;
        tick();
        check("flush_pre_occ", occ[1], 2);
        flush[1]  = 1'b1;
        s_data[1] = 16'h00FF;
        tick();
        flush[1]   = 1'b0;
        s_valid[1] = 1'b0;
        check("flush_mvalid", m_valid[1], 0);
        check("flush_occ", occ[1], 0);
        check("flush_sready", s_ready[1], 1);
        m_ready[1] = 1'b1;
        repeat (3) tick();
        check("flush_quiet", m_valid[1], 0);
        m_ready[1] = 1'b0;

        // PIPE flush concurrent with a transfer and an upstream beat.
        s_valid[0] = 1'b1;
        s_data[0]  = 16'h0011;
        tick();
        x0 = xfer[0];
        flush[0]   = 1'b1;
        m_ready[0] = 1'b1;
        s_data[0]  = 16'h00EE;
        tick();
        flush[0]   = 1'b0;
        s_valid[0] = 1'b0;
        check("pflush_mvalid", m_valid[0], 0);
        check("pflush_occ", occ[0], 0);
        check("pflush_xfer", xfer[0], x0 + 1);
        repeat (2) tick();
        check("pflush_quiet", m_valid[0], 0);

        // PIPE under random backpressure.
        for (int i = 0; i < 120; i++) begin
            s_valid[0] = 1'($urandom_range(0, 1));
            s_data[0]  = DW'($urandom);
            m_ready[0] = 1'($urandom_range(0, 1));
            tick();
        end
        s_valid[0] = 1'b0;
        m_ready[0] = 1'b1;
        repeat (3) tick();
        check("rand_drained", mon[0].q.size(), 0);
        check("rand_occ", occ[0], 0);

        // 4-bit counters: 17 transfers wrap to 1; clear beats a concurrent transfer.
        for (int i = 0; i < 17; i++) begin
            s_valid[2] = 1'b1;
            m_ready[2] = 1'b1;
            s_data[2]  = DW'(16'h2000 + i);
            tick();
        end
        s_valid[2] = 1'b0;
        tick();
        check("cnt4_wrap", xfer4, 1);
        check("cnt4_stall", stall4, 0);
        s_valid[2] = 1'b1;
        s_data[2]  = 16'h0077;
        tick();
        s_valid[2] = 1'b0;
        cnt_clr[2] = 1'b1;
        tick();
        cnt_clr[2] = 1'b0;
        check("cnt4_clr", xfer4, 0);
        check("cnt4_mvalid", m_valid[2], 0);

        // Asynchronous reset mid-transfer on the SKID instance.
        m_ready[1] = 1'b0;
        s_valid[1] = 1'b1;
        s_data[1]  = 16'h00C1;
        tick();
        s_valid[1] = 1'b0;
        check("areset_pre", m_valid[1], 1);
        #2;
        rst_n = 1'b0;
        #1;
        check("areset_mvalid", m_valid[1], 0);
        check("areset_occ", occ[1], 0);
        check("areset_xfer", xfer[1], 0);
        check("areset_sready", s_ready[1], 1);
        tick();
        rst_n = 1'b1;
        m_ready[1] = 1'b1;
        repeat (3) tick();
        check("areset_quiet", m_valid[1], 0);

        check("sb_final0", mon[0].q.size(), 0);
        check("sb_final1", mon[1].q.size(), 0);
        check("sb_final2", mon[2].q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
